// File: rtl/result_streamer.sv
// result_streamer
// Reads DEPTH result words from the multiplier's result memory and shifts
// each one out MSB-first over a one-bit valid/ready link, then pulses done.
// Optional feature macro: RESULT_STREAMER_PARITY_EN appends one even-parity
// bit (XOR of the loaded word) after the data bits of every word.
// Every output is driven straight from a flop, so there is no combinational
// path from tx_ready or start to any output.
module result_streamer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

`ifdef RESULT_STREAMER_PARITY_EN
  localparam int BITS_W = DATA_W + 1;
`else
  localparam int BITS_W = DATA_W;
`endif

  localparam int                BC_W      = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0]   LAST_BIT  = BC_W'(BITS_W - 1);
  localparam logic [BC_W-1:0]   BIT_ZERO  = BC_W'(0);
  localparam logic [BC_W-1:0]   BIT_ONE   = BC_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [BITS_W-1:0] SH_ZERO   = BITS_W'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   addr_s;
  logic [BC_W-1:0]     bitcnt_r;
  logic [BC_W-1:0]     bitcnt_s;
  logic [BITS_W-1:0]   shreg_r;
  logic [BITS_W-1:0]   shreg_s;

  logic                mem_rd_r;
  logic                tx_bit_r;
  logic                tx_valid_r;
  logic                tx_last_r;
  logic                busy_r;
  logic                done_r;

  logic                mem_rd_s;
  logic                tx_bit_s;
  logic                tx_valid_s;
  logic                tx_last_s;
  logic                busy_s;
  logic                done_s;

`ifdef RESULT_STREAMER_PARITY_EN
  // Even parity over one result word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    even_parity = ^word;
  endfunction
`endif

  // Shift-register image of a freshly read word (data, then parity if enabled).
  function automatic logic [BITS_W-1:0] load_image(input logic [DATA_W-1:0] word);
`ifdef RESULT_STREAMER_PARITY_EN
    load_image = {word, even_parity(word)};
`else
    load_image = word;
`endif
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, datapath next values and next output values.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    bitcnt_s = bitcnt_r;
    shreg_s  = shreg_r;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          addr_s  = ADDR_ZERO;
          state_s = S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        // Read data is valid this cycle; capture it and start a new word.
        shreg_s  = load_image(mem_rdata);
        bitcnt_s = BIT_ZERO;
        state_s  = S_SHIFT;
      end
      S_SHIFT: begin
        // tx_valid is high throughout SHIFT, so tx_ready alone completes a transfer.
        if (tx_ready) begin
          shreg_s = {shreg_r[BITS_W-2:0], 1'b0};
          if (bitcnt_r == LAST_BIT) begin
            bitcnt_s = BIT_ZERO;
            state_s  = S_NEXT;
          end else begin
            bitcnt_s = bitcnt_r + BIT_ONE;
            state_s  = S_SHIFT;
          end
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_NEXT: begin
        if (addr_r == LAST_ADDR) begin
          state_s = S_DONE;
        end else begin
          addr_s  = addr_r + ADDR_ONE;
          state_s = S_READ;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s  = S_IDLE;
        addr_s   = ADDR_ZERO;
        bitcnt_s = BIT_ZERO;
        shreg_s  = SH_ZERO;
      end
    endcase

    // Outputs are pre-decoded from the next state so they can be registered
    // and still line up cycle-for-cycle with the state they describe.
    mem_rd_s   = (state_s == S_READ);
    tx_valid_s = (state_s == S_SHIFT);
    tx_bit_s   = (state_s == S_SHIFT) && shreg_s[BITS_W-1];
    tx_last_s  = (state_s == S_SHIFT) && (addr_s == LAST_ADDR) && (bitcnt_s == LAST_BIT);
    busy_s     = (state_s != S_IDLE);
    done_s     = (state_s == S_DONE);
  end

  // Address counter, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r   <= ADDR_ZERO;
      bitcnt_r <= BIT_ZERO;
      shreg_r  <= SH_ZERO;
    end else begin
      addr_r   <= addr_s;
      bitcnt_r <= bitcnt_s;
      shreg_r  <= shreg_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_rd_r   <= 1'b0;
      tx_bit_r   <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      mem_rd_r   <= mem_rd_s;
      tx_bit_r   <= tx_bit_s;
      tx_valid_r <= tx_valid_s;
      tx_last_r  <= tx_last_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign mem_rd   = mem_rd_r;
  assign mem_addr = addr_r;
  assign tx_bit   = tx_bit_r;
  assign tx_valid = tx_valid_r;
  assign tx_last  = tx_last_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: a DEPTH=2 instance for the main
// runs and a DEPTH=1 instance for the single-word case. Expected bitstreams
// come from a word/bit-index model of the serial format.
module tb_result_streamer;

  localparam int DATA_W = 32;
`ifdef RESULT_STREAMER_PARITY_EN
  localparam int B = DATA_W + 1;
`else
  localparam int B = DATA_W;
`endif
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        mem_rd;
  logic [2:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic        done;

  logic        o_start;
  logic        o_mem_rd;
  logic [0:0]  o_mem_addr;
  logic [31:0] o_rdata;
  logic        o_tx_bit;
  logic        o_tx_valid;
  logic        o_tx_ready;
  logic        o_tx_last;
  logic        o_busy;
  logic        o_done;

  logic [31:0] mem [0:7];
  logic [31:0] o_word;

  int checks   = 0;
  int failures = 0;
  bit got_q[$];

  result_streamer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .busy(busy), .done(done)
  );

  result_streamer #(.DEPTH(1), .DATA_W(DATA_W), .ADDR_W(1)) u_one (
    .clk(clk), .rst(rst), .start(o_start), .mem_rd(o_mem_rd), .mem_addr(o_mem_addr),
    .mem_rdata(o_rdata), .tx_bit(o_tx_bit), .tx_valid(o_tx_valid), .tx_ready(o_tx_ready),
    .tx_last(o_tx_last), .busy(o_busy), .done(o_done)
  );

  // Result memory models: data one cycle after the read strobe, noise otherwise.
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? mem[mem_addr] : $urandom;
    o_rdata   <= o_mem_rd ? o_word : $urandom;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i (0 = first sent) of one word on the wire.
  function automatic bit model_bit(input logic [31:0] w, input int i);
    if (i < DATA_W) return w[DATA_W-1-i];
    return ^w;
  endfunction

  // One full run of the DEPTH=2 instance. mode 0: ready high, 1: alternating,
  // 2: random. extra_starts pulses start at cycles 5 and 20 of the run.
  task automatic run(input string tag, input int mode, input bit extra_starts, output int done_c);
    int rd_addrs[$];
    int last_idx[$];
    int c, stalls, first_v, unstable, not_busy, bad_bits, after;
    bit prev_stall, prev_bit;
    got_q.delete();
    stalls = 0; done_c = -1; first_v = -1; unstable = 0; not_busy = 0;
    prev_stall = 1'b0; prev_bit = 1'b0;
    start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; c = 1;
    while (c < 2000 && done_c < 0) begin
      if (mem_rd) rd_addrs.push_back(int'(mem_addr));
      if (tx_valid && first_v < 0) first_v = c;
      if (prev_stall && (!tx_valid || tx_bit !== prev_bit)) unstable++;
      if (!busy) not_busy++;
      if (done) begin
        done_c = c;
      end else begin
        case (mode)
          0: tx_ready = 1'b1;
          1: tx_ready = (c % 2 == 0);
          default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        start = extra_starts && (c == 5 || c == 20);
        prev_stall = tx_valid && !tx_ready;
        prev_bit = tx_bit;
        if (prev_stall) stalls++;
        if (tx_valid && tx_ready) begin
          if (tx_last) last_idx.push_back(got_q.size());
          got_q.push_back(tx_bit);
        end
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    check($sformatf("%s_done_cycle", tag), done_c, 1 + DEPTH * (B + 3) + stalls);
    check($sformatf("%s_first_valid", tag), first_v, 3);
    check($sformatf("%s_read_count", tag), rd_addrs.size(), DEPTH);
    foreach (rd_addrs[i]) check($sformatf("%s_read_addr%0d", tag, i), rd_addrs[i], i);
    check($sformatf("%s_bit_count", tag), got_q.size(), DEPTH * B);
    bad_bits = 0;
    foreach (got_q[k]) if (k < DEPTH * B && got_q[k] != model_bit(mem[k / B], k % B)) bad_bits++;
    check($sformatf("%s_bit_errors", tag), bad_bits, 0);
    check($sformatf("%s_last_pos", tag), last_idx.size() == 1 ? last_idx[0] : -1, DEPTH * B - 1);
    check($sformatf("%s_stall_hold", tag), unstable, 0);
    check($sformatf("%s_busy_gaps", tag), not_busy, 0);
    after = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || done) after++;
    end
    check($sformatf("%s_idle_after", tag), after, 0);
  endtask

  initial begin
    int d, c, ones_bad, last_pos, cnt;
    rst = 1'b0; start = 1'b0; tx_ready = 1'b0;
    o_start = 1'b0; o_tx_ready = 1'b1; o_word = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {mem_rd, mem_addr, tx_bit, tx_valid, tx_last, busy, done}, 64'd0);
    check("reset_outputs_one", {o_mem_rd, o_mem_addr, o_tx_bit, o_tx_valid, o_tx_last, o_busy, o_done}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic run.
    mem[0] = 32'h8000_0001; mem[1] = 32'h0000_FFFF;
    run("basic", 0, 1'b0, d);
`ifndef RESULT_STREAMER_PARITY_EN
    check("basic_done_71", d, 71);
`endif

    // Back-pressure on alternate cycles.
    run("backpressure", 1, 1'b0, d);

    // Start pulses during a run are ignored.
    run("ignored_start", 0, 1'b1, d);

    // Reset in the middle of a run.
    start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("midreset_outputs", {mem_rd, mem_addr, tx_bit, tx_valid, tx_last, busy, done}, 64'd0);
    rst = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    check("midreset_no_done", cnt, 0);
    run("after_reset", 0, 1'b0, d);

    // Randomized words and random back-pressure.
    for (int r = 0; r < 4; r++) begin
      mem[0] = $urandom; mem[1] = $urandom;
      run($sformatf("random%0d", r), 2, 1'b0, d);
    end

`ifdef RESULT_STREAMER_PARITY_EN
    // Parity run.
    mem[0] = 32'h0000_0007; mem[1] = 32'h0000_0003;
    run("parity", 0, 1'b0, d);
    check("parity_done_73", d, 73);
    check("parity_total_bits", got_q.size(), 66);
    check("parity_bit_w0", got_q.size() > 32 ? got_q[32] : 1'bx, 1'b1);
    check("parity_bit_w1", got_q.size() > 65 ? got_q[65] : 1'bx, 1'b0);
`endif

    // Single-word instance with an all-ones word.
    o_start = 1'b1;
    @(posedge clk); #1;
    o_start = 1'b0;
    c = 1; d = -1; cnt = 0; ones_bad = 0; last_pos = -1;
    while (c < 500 && d < 0) begin
      if (o_done) begin
        d = c;
      end else begin
        if (o_tx_valid) begin
          if (o_tx_last) last_pos = cnt;
          if (o_tx_bit != model_bit(o_word, cnt % B)) ones_bad++;
          cnt++;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    check("one_bit_count", cnt, B);
    check("one_bit_errors", ones_bad, 0);
    check("one_last_pos", last_pos, B - 1);
    check("one_done_cycle", d, 1 + (B + 3));
`ifndef RESULT_STREAMER_PARITY_EN
    check("one_done_36", d, 36);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
